// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter:
// opcodes, flag positions and the arbiter FSM states.
package alu_pkg;

   localparam logic [3:0] ADD    = 4'd0;
   localparam logic [3:0] SUB    = 4'd1;
   localparam logic [3:0] AND    = 4'd2;
   localparam logic [3:0] OR     = 4'd3;
   localparam logic [3:0] SLL    = 4'd4;
   localparam logic [3:0] XNOR   = 4'd5;
   localparam logic [3:0] OP_MAX = 4'd5;

   localparam int FLAG_C = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_S = 0;

   // Response flags for an illegal opcode: zero only.
   localparam logic [3:0] ILL_FLAGS = 4'b0100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_MAX;
   endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, ALU and response signals.
// slave = arbiter side, master = surrounding logic.
interface alu_rr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = 2
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*4-1:0]     req_opcode;
   logic [NUM_REQ*WIDTH-1:0] req_input1;
   logic [NUM_REQ*WIDTH-1:0] req_input2;
   logic [NUM_REQ*5-1:0]     req_shift;

   logic [3:0]               alu_opcode;
   logic [WIDTH-1:0]         alu_input1;
   logic [WIDTH-1:0]         alu_input2;
   logic [4:0]               alu_shiftValue;
   logic [WIDTH-1:0]         alu_result;
   logic [3:0]               alu_flags;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_result;
   logic [3:0]               rsp_flags;
   logic                     rsp_err;

   modport slave (
      input  req_valid, req_opcode, req_input1,
      input  req_input2, req_shift,
      output req_ready,
      output alu_opcode, alu_input1, alu_input2,
      output alu_shiftValue,
      input  alu_result, alu_flags,
      output rsp_valid, rsp_id, rsp_result,
      output rsp_flags, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_opcode, req_input1,
      output req_input2, req_shift,
      input  req_ready,
      input  alu_opcode, alu_input1, alu_input2,
      input  alu_shiftValue,
      output alu_result, alu_flags,
      input  rsp_valid, rsp_id, rsp_result,
      input  rsp_flags, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/alu_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: first valid
// index strictly after ptr, wrapping modulo N.
module rr_grant #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          hit
);

   int c;

   // scan ptr+1 .. ptr+N, keep the first hit
   always_comb begin
      grant = '0;
      idx   = '0;
      hit   = 1'b0;
      c     = 0;
      for (int k = 1; k <= N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!hit && valid[c]) begin
            hit      = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ
// requesters; one op in flight, tagged response.
module alu_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = 2
) (
   input logic             clk,
   input logic             rst,
   alu_rr_arbiter_if.slave bus
);

   import alu_pkg::*;

   state_t state;
   state_t state_nx;

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    gidx;
   logic               any_req;
   logic               can_grant;
   logic               do_grant;

   logic [3:0]         sel_op;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;
   logic [4:0]         sel_sh;

   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [4:0]         sh_q;

   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [WIDTH-1:0]   rsp_result_q;
   logic [3:0]         rsp_flags_q;
   logic               rsp_err_q;

   rr_grant #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_grant (
      .valid (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx),
      .hit   (any_req)
   );

   // grant window: idle, or response retiring now
   always_comb begin
      can_grant = 1'b0;
      unique case (state)
         IDLE:    can_grant = 1'b1;
         RESP:    can_grant = bus.rsp_ready;
         default: can_grant = 1'b0;
      endcase
      do_grant = can_grant && any_req && !rst;
   end

   assign bus.req_ready = do_grant ? grant : '0;

   // select the winning requester's operands
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      sel_sh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_op = bus.req_opcode[i*4 +: 4];
            sel_a  = bus.req_input1[i*WIDTH +: WIDTH];
            sel_b  = bus.req_input2[i*WIDTH +: WIDTH];
            sel_sh = bus.req_shift[i*5 +: 5];
         end
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (any_req) state_nx = EXEC;
         end
         EXEC: state_nx = RESP;
         RESP: begin
            if (bus.rsp_ready)
               state_nx = any_req ? EXEC : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // latch granted operands and advance pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= ID_W'(NUM_REQ - 1);
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         sh_q <= '0;
      end else if (do_grant) begin
         ptr  <= gidx;
         op_q <= sel_op;
         a_q  <= sel_a;
         b_q  <= sel_b;
         sh_q <= sel_sh;
      end
   end

   // capture ALU output, hold until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else if (state == EXEC) begin
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= ptr;
         if (op_legal(op_q)) begin
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= bus.alu_flags;
            rsp_err_q    <= 1'b0;
         end else begin
            rsp_result_q <= '0;
            rsp_flags_q  <= ILL_FLAGS;
            rsp_err_q    <= 1'b1;
         end
      end else if (state == RESP && bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.alu_opcode     = op_q;
   assign bus.alu_input1     = a_q;
   assign bus.alu_input2     = b_q;
   assign bus.alu_shiftValue = sh_q;

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule
